// File: rtl/norm_shift_pipe.sv
// Two-stage leading-one normaliser for the FP divider: S1 captures the beat and its
// leading-zero count, S2 holds the left-justified mantissa and the adjusted exponent.
module norm_shift_pipe #(
  parameter int N     = 24,
  parameter int EW    = 8,
  parameter int TAG_W = 4,
  parameter int CW    = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_mant,
  input  logic [EW-1:0]    in_exp,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_mant,
  output logic [EW-1:0]    out_exp,
  output logic [CW-1:0]    out_lzc,
  output logic [CW-1:0]    out_pos,
  output logic             out_zero,
  output logic             out_uflow,
  output logic [TAG_W-1:0] out_tag
);

  // Exponent/count comparison width: wide enough for either operand plus a guard bit.
  localparam int XW = ((EW > CW) ? EW : CW) + 1;

  logic             r_v1;
  logic [N-1:0]     r_mant1;
  logic [EW-1:0]    r_exp1;
  logic [TAG_W-1:0] r_tag1;
  logic [CW-1:0]    r_lzc1;

  logic             r_v2;
  logic [N-1:0]     r_mant2;
  logic [EW-1:0]    r_exp2;
  logic [CW-1:0]    r_lzc2;
  logic [CW-1:0]    r_pos2;
  logic             r_zero2;
  logic             r_uflow2;
  logic [TAG_W-1:0] r_tag2;

  logic             w_adv2;
  logic             w_accept;
  logic [CW-1:0]    w_lzc;
  logic             w_zero1;
  logic [XW-1:0]    w_exp_x;
  logic [XW-1:0]    w_lzc_x;
  logic [CW-1:0]    w_shift;
  logic [EW-1:0]    w_exp2;
  logic             w_uflow2;
  logic [N-1:0]     w_mant2;
  logic [CW-1:0]    w_pos2;

  assign w_adv2   = !r_v2 || out_ready;
  assign in_ready = !r_v1 || w_adv2;
  assign w_accept = in_valid && in_ready;

  // Highest set bit wins because later loop iterations overwrite earlier ones.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_lzc = CW'(N);
    for (int i = 0; i < N; i++) begin
      if (in_mant[i]) w_lzc = CW'(N - 1 - i);
    end
  end

  assign w_zero1 = (r_mant1 == '0);
  assign w_exp_x = XW'(r_exp1);
  assign w_lzc_x = XW'(r_lzc1);

  // Underflow keeps the exponent at zero and shifts only as far as the exponent allows.
  always_comb begin
    w_shift  = '0;
    w_exp2   = '0;
    w_uflow2 = 1'b0;
    if (!w_zero1) begin
      if (w_exp_x > w_lzc_x) begin
        w_shift = r_lzc1;
        w_exp2  = EW'(w_exp_x - w_lzc_x);
      end else begin
        w_uflow2 = 1'b1;
        if (r_exp1 != '0) w_shift = CW'(r_exp1 - EW'(1));
      end
    end
  end

  assign w_mant2 = r_mant1 << w_shift;
  assign w_pos2  = w_zero1 ? '0 : r_lzc1 + CW'(1);

  // NOTE: sequential state uses non-blocking assignments so both stages update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1    <= 1'b0;
      r_mant1 <= '0;
      r_exp1  <= '0;
      r_tag1  <= '0;
      r_lzc1  <= '0;
    end else if (in_ready) begin
      r_v1 <= in_valid;
      if (w_accept) begin
        r_mant1 <= in_mant;
        r_exp1  <= in_exp;
        r_tag1  <= in_tag;
        r_lzc1  <= w_lzc;
      end
    end
  end

  // S2 holds its data while stalled, so the outputs are stable under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v2     <= 1'b0;
      r_mant2  <= '0;
      r_exp2   <= '0;
      r_lzc2   <= '0;
      r_pos2   <= '0;
      r_zero2  <= 1'b0;
      r_uflow2 <= 1'b0;
      r_tag2   <= '0;
    end else if (w_adv2) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_mant2  <= w_mant2;
        r_exp2   <= w_exp2;
        r_lzc2   <= r_lzc1;
        r_pos2   <= w_pos2;
        r_zero2  <= w_zero1;
        r_uflow2 <= w_uflow2;
        r_tag2   <= r_tag1;
      end
    end
  end

  assign out_valid = r_v2;
  assign out_mant  = r_mant2;
  assign out_exp   = r_exp2;
  assign out_lzc   = r_lzc2;
  assign out_pos   = r_pos2;
  assign out_zero  = r_zero2;
  assign out_uflow = r_uflow2;
  assign out_tag   = r_tag2;

endmodule
